// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD clocking types and divider constants
package sd_pkg;

  typedef enum logic [1:0] {
    SD_IDLE = 2'd0,
    SD_HIGH = 2'd1,
    SD_LOW  = 2'd2
  } sd_state_e;

  localparam int SD_INIT_CLKS = 80;
  // sd_clk period = 2*(div+1) clkin cycles from a ~50 MHz source
  localparam int SD_DIV_ID    = 62;
  localparam int SD_DIV_DS    = 0;

endpackage

// File: rtl/sd_clk_gen.sv
// rtl/sd_clk_gen.sv - glitch-free programmable SD clock divider with init burst
module sd_clk_gen
  import sd_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int INIT_DIV  = SD_DIV_ID,
  parameter int INIT_CLKS = SD_INIT_CLKS
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             en_i,
  input  logic             burst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_busy_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             sd_clk_o,
  output logic             rise_stb_o,
  output logic             fall_stb_o,
  output logic             running_o,
  output logic             burst_done_o
);

  localparam int BCW = $clog2(INIT_CLKS + 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(INIT_DIV);
  localparam logic [BCW-1:0]   BURST_LD = BCW'(INIT_CLKS);

  sd_state_e        state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] next_div;
  logic [BCW-1:0]   burst_cnt;
  logic             burst_act;
  logic             run;
  logic             apply_div;
  logic             boundary;

  assign run       = en_i | (burst_cnt != '0);
  assign eff_div   = div_load_i ? div_i : pend_div;
  assign apply_div = div_busy_o | div_load_i;
  assign next_div  = apply_div ? eff_div : cur_div_o;
  assign boundary  = (state == SD_LOW) && (cnt == '0);

  // Divider changes only land in IDLE or at the end of a low phase, so no runt pulses.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state      <= SD_IDLE;
      cnt        <= '0;
      pend_div   <= DIV_RST;
      cur_div_o  <= DIV_RST;
      div_busy_o <= 1'b0;
      sd_clk_o   <= 1'b0;
      rise_stb_o <= 1'b0;
      fall_stb_o <= 1'b0;
      running_o  <= 1'b0;
    end else begin
      rise_stb_o <= 1'b0;
      fall_stb_o <= 1'b0;
      if (div_load_i) begin
        pend_div   <= div_i;
        div_busy_o <= 1'b1;
      end
      case (state)
        SD_IDLE: begin
          sd_clk_o <= 1'b0;
          if (apply_div) begin
            cur_div_o  <= eff_div;
            div_busy_o <= 1'b0;
          end
          if (run) begin
            sd_clk_o   <= 1'b1;
            rise_stb_o <= 1'b1;
            cnt        <= next_div;
            state      <= SD_HIGH;
            running_o  <= 1'b1;
          end
        end
        SD_HIGH: begin
          if (cnt == '0) begin
            sd_clk_o   <= 1'b0;
            fall_stb_o <= 1'b1;
            cnt        <= cur_div_o;
            state      <= SD_LOW;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        SD_LOW: begin
          if (cnt == '0) begin
            if (apply_div) begin
              cur_div_o  <= eff_div;
              div_busy_o <= 1'b0;
            end
            if (run) begin
              sd_clk_o   <= 1'b1;
              rise_stb_o <= 1'b1;
              cnt        <= next_div;
              state      <= SD_HIGH;
            end else begin
              state     <= SD_IDLE;
              running_o <= 1'b0;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: begin
          state     <= SD_IDLE;
          sd_clk_o  <= 1'b0;
          running_o <= 1'b0;
        end
      endcase
    end
  end

  // A burst counts registered rise strobes; a new load outranks a coincident rise.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      burst_cnt    <= '0;
      burst_act    <= 1'b0;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;
      if (boundary && burst_act && (burst_cnt == '0)) begin
        burst_done_o <= 1'b1;
        burst_act    <= 1'b0;
      end
      if (burst_i && (burst_cnt == '0)) begin
        burst_cnt <= BURST_LD;
        burst_act <= 1'b1;
      end else if (rise_stb_o && (burst_cnt != '0)) begin
        burst_cnt <= burst_cnt - BCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb/tb_sd_clk_gen.sv - directed self-checking bench for sd_clk_gen
module tb_sd_clk_gen;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       en_i;
  logic       burst_i;
  logic [7:0] div_i;
  logic       div_load_i;
  logic       div_busy_o;
  logic [7:0] cur_div_o;
  logic       sd_clk_o;
  logic       rise_stb_o;
  logic       fall_stb_o;
  logic       running_o;
  logic       burst_done_o;

  int tests = 0;
  int fails = 0;
  int n;
  int rises;
  int dones;
  int last_rise;
  int done_at;
  int strobes;

  always #10 clkin = ~clkin;

  sd_clk_gen dut (
    .clkin        (clkin),
    .resetn       (resetn),
    .en_i         (en_i),
    .burst_i      (burst_i),
    .div_i        (div_i),
    .div_load_i   (div_load_i),
    .div_busy_o   (div_busy_o),
    .cur_div_o    (cur_div_o),
    .sd_clk_o     (sd_clk_o),
    .rise_stb_o   (rise_stb_o),
    .fall_stb_o   (fall_stb_o),
    .running_o    (running_o),
    .burst_done_o (burst_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (sd_clk_o === lvl && len < 1000) begin
      len++;
      @(negedge clkin);
    end
  endtask

  task automatic wait_rise(input string tag);
    int k;
    k = 0;
    @(negedge clkin);
    while (rise_stb_o !== 1'b1 && k < 400) begin
      k++;
      @(negedge clkin);
    end
    chk(tag, 32'(rise_stb_o), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; en_i = 1'b0; burst_i = 1'b0; div_i = 8'd0; div_load_i = 1'b0;
    @(negedge clkin);
    chk("rst_sd_clk", 32'(sd_clk_o), 0);
    chk("rst_cur_div", 32'(cur_div_o), 62);
    chk("rst_busy", 32'(div_busy_o), 0);
    chk("rst_running", 32'(running_o), 0);
    chk("rst_strobes", 32'({rise_stb_o, fall_stb_o, burst_done_o}), 0);
    resetn = 1'b1;
    @(negedge clkin);
    chk("idle_sd_clk", 32'(sd_clk_o), 0);

    // enable: one-cycle latency, 63 high / 63 low at div 62
    en_i = 1'b1;
    @(negedge clkin);
    chk("t1_rise_stb", 32'(rise_stb_o), 1);
    chk("t1_sd_clk", 32'(sd_clk_o), 1);
    chk("t1_running", 32'(running_o), 1);
    run_len(1'b1, n);
    chk("t1_high_len", 32'(n), 63);
    chk("t1_fall_stb", 32'(fall_stb_o), 1);
    run_len(1'b0, n);
    chk("t1_low_len", 32'(n), 63);
    chk("t1_rise2", 32'(rise_stb_o), 1);

    // load div 0 mid-high: period completes at 62, then period 2
    repeat (5) @(negedge clkin);
    div_i = 8'd0; div_load_i = 1'b1;
    @(negedge clkin);
    div_load_i = 1'b0;
    chk("t2_busy_set", 32'(div_busy_o), 1);
    chk("t2_cur_old", 32'(cur_div_o), 62);
    run_len(1'b1, n);
    chk("t2_high_rem", 32'(n), 57);
    chk("t2_busy_low", 32'(div_busy_o), 1);
    run_len(1'b0, n);
    chk("t2_low_len", 32'(n), 63);
    chk("t2_busy_clr", 32'(div_busy_o), 0);
    chk("t2_cur_new", 32'(cur_div_o), 0);
    run_len(1'b1, n);
    chk("t2_fast_high", 32'(n), 1);
    chk("t2_fast_fall", 32'(fall_stb_o), 1);
    run_len(1'b0, n);
    chk("t2_fast_low", 32'(n), 1);
    chk("t2_fast_rise", 32'(rise_stb_o), 1);

    // switch to div 3, then load div 9 exactly on the low terminal cycle
    div_i = 8'd3; div_load_i = 1'b1;
    @(negedge clkin);
    div_load_i = 1'b0;
    wait_rise("t6_sync3");
    chk("t6_cur3", 32'(cur_div_o), 3);
    run_len(1'b1, n);
    chk("t6_high3", 32'(n), 4);
    repeat (3) @(negedge clkin);
    div_i = 8'd9; div_load_i = 1'b1;
    @(negedge clkin);
    div_load_i = 1'b0;
    chk("t6_rise", 32'(rise_stb_o), 1);
    chk("t6_busy", 32'(div_busy_o), 0);
    chk("t6_cur9", 32'(cur_div_o), 9);
    run_len(1'b1, n);
    chk("t6_high9", 32'(n), 10);
    run_len(1'b0, n);
    chk("t6_low9", 32'(n), 10);

    // back to div 3, drop en_i mid-high
    div_i = 8'd3; div_load_i = 1'b1;
    @(negedge clkin);
    div_load_i = 1'b0;
    wait_rise("t3_sync");
    @(negedge clkin);
    en_i = 1'b0;
    run_len(1'b1, n);
    chk("t3_high_rem", 32'(n), 3);
    repeat (3) @(negedge clkin);
    chk("t3_low_sd", 32'(sd_clk_o), 0);
    chk("t3_running_l3", 32'(running_o), 1);
    @(negedge clkin);
    chk("t3_running_off", 32'(running_o), 0);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      if (rise_stb_o || fall_stb_o || sd_clk_o) strobes++;
      @(negedge clkin);
    end
    chk("t3_quiet", 32'(strobes), 0);

    // init burst with en_i low; a second pulse mid-burst is ignored
    burst_i = 1'b1;
    @(negedge clkin);
    burst_i = 1'b0;
    rises = 0; dones = 0; last_rise = -1; done_at = -1;
    for (int i = 0; i < 740; i++) begin
      if (i == 100) burst_i = 1'b1;
      if (i == 101) burst_i = 1'b0;
      if (rise_stb_o) begin rises++; last_rise = i; end
      if (burst_done_o) begin dones++; done_at = i; end
      @(negedge clkin);
    end
    chk("t4_rises", 32'(rises), 80);
    chk("t4_dones", 32'(dones), 1);
    chk("t4_done_gap", 32'(done_at - last_rise), 8);
    chk("t4_idle_run", 32'(running_o), 0);
    chk("t4_idle_sd", 32'(sd_clk_o), 0);

    // burst load coinciding with a rise, then async reset mid-high
    en_i = 1'b1;
    wait_rise("t5_sync");
    div_i = 8'd7; div_load_i = 1'b1; burst_i = 1'b1;
    @(negedge clkin);
    div_load_i = 1'b0; burst_i = 1'b0;
    chk("t5_burst_load", 32'(dut.burst_cnt), 80);
    chk("t5_busy_pre", 32'(div_busy_o), 1);
    chk("t5_sd_pre", 32'(sd_clk_o), 1);
    #5 resetn = 1'b0;
    #1;
    chk("t5_sd_async", 32'(sd_clk_o), 0);
    chk("t5_cur_div", 32'(cur_div_o), 62);
    chk("t5_busy", 32'(div_busy_o), 0);
    chk("t5_burst_cnt", 32'(dut.burst_cnt), 0);
    chk("t5_running", 32'(running_o), 0);
    @(negedge clkin);
    resetn = 1'b1;
    en_i = 1'b0;
    @(negedge clkin);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
